exec_branch_unit: RTL
=====================

EXEC_BRANCH_UNIT -- requirements
Module: exec_branch_unit

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 Parameter ALEN, default 32: address width.
REQ-003 Parameter C_EXT, default 1: 1 means 2-byte target alignment; 0 means 4-byte alignment.
REQ-004 Parameter MPCNT_W, default 16: mispredict counter width.
REQ-005 Port list, one per line:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- decode_instruction_addr  in  ALEN  PC of the current instruction.
- decode_instruction_next_addr  in  ALEN  PC+2 or PC+4 of the current instruction.
- opcode  in  5  decode_types opcode; OP_JAL, OP_JALR and OP_BRANCH are handled.
- funct3  in  3  branch condition.
- rs1_data, rs2_data  in  XLEN each  operands.
- j_imm  in  [20:1]  JAL offset.
- b_imm  in  [12:1]  conditional-branch offset.
- i_imm  in  12  JALR offset.
- input_valid_unless_mispredict  in  1  instruction is valid if no mispredict is flagged this cycle.
- input_valid  in  1  instruction is valid and not squashed.
- input_is_branch  in  1  instruction belongs to this unit.
- exec_branch_output_valid  out  1  result registers valid.
- exec_branch_exception  out  1  misaligned target or illegal funct3.
- exec_branch_taken  out  1  branch resolved taken.
- exec_branch_result  out  XLEN  link value (next_addr, zero-extended or truncated to XLEN).
- exec_branch_target  out  ALEN  resolved next PC.
- exec_mispredict_detected  out  1  combinational mispredict flag.
- exec_mispredict_count  out  MPCNT_W  saturating count of mispredicts.

Function
REQ-006 "Accept" SHALL mean input_valid && input_is_branch at a rising edge.
REQ-007 Target computation SHALL be:
- JAL: PC + sext(j_imm<<1).
- JALR: (rs1_data[ALEN-1:0] + sext(i_imm)) with bit 0 cleared.
- OP_BRANCH: PC + sext(b_imm<<1).
- All sums wrap modulo 2^ALEN.
REQ-008 Taken SHALL be:
- JAL and JALR: always taken.
- OP_BRANCH by funct3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
- funct3 010 or 011: not taken, and exception raised.
REQ-009 Resolved next PC SHALL be the target if taken, else decode_instruction_next_addr.
REQ-010 Exception SHALL be: (illegal funct3) OR (taken AND target[0]) OR (taken AND C_EXT==0 AND target[1]).
REQ-011 On accept, exec_branch_target, exec_branch_taken, exec_branch_exception and exec_branch_result SHALL register with 1-cycle latency; exec_branch_output_valid SHALL equal accept, delayed one cycle.
REQ-012 When there is no accept, the data outputs SHALL hold their previous values.
REQ-013 Expectation tracker SHALL have two states, IDLE and EXPECT, plus an ALEN-wide expected_pc register.
REQ-014 Tracker update SHALL occur only when input_valid_unless_mispredict is 1:
- On accept: go to EXPECT and load expected_pc with the resolved next PC, whether taken or not.
- Otherwise: go to IDLE.
REQ-015 exec_mispredict_detected SHALL equal input_valid_unless_mispredict && state==EXPECT && expected_pc != decode_instruction_addr, with no registering.
REQ-016 A mispredict cycle SHALL itself obey REQ-014. Upstream holds input_valid low during a mispredict, so the tracker returns to IDLE.
REQ-017 A cycle with input_valid_unless_mispredict low SHALL leave state and expected_pc unchanged (pipeline bubble or stall).
REQ-018 Back-to-back branches SHALL work: the second branch is compared against the first branch's expectation and, if accepted, replaces it in the same edge.
REQ-019 exec_mispredict_count SHALL increment by 1 on each edge where exec_mispredict_detected is 1, and saturate at all-ones.
REQ-020 A non-branch opcode flagged as input_is_branch SHALL produce target = next_addr, taken = 0, exception = 0.

Reset
REQ-021 While rst_n is low at an edge, the following SHALL be forced: exec_branch_output_valid=0, state=IDLE, exec_mispredict_count=0, exec_branch_taken=0, exec_branch_exception=0.
REQ-022 exec_branch_target, exec_branch_result and expected_pc SHALL be don't-care after reset.
REQ-023 Reset SHALL take priority over a simultaneous accept.
REQ-024 Reset asserted mid-expectation SHALL discard the expectation, so the first instruction after reset never flags a mispredict.

Verification
REQ-025 JAL at PC 0x100, j_imm=0x10 (+0x20), next_addr 0x104 -> next cycle: valid=1, target=0x120, result=0x104, taken=1. Following instruction at 0x104 -> mispredict=1 and count=1. At 0x120 instead -> mispredict=0.
REQ-026 BEQ at PC 0x200, rs1=rs2=5, b_imm=-4 (target 0x1F8) -> taken, target 0x1F8. BEQ with rs1=5, rs2=6 -> not taken, target 0x204 (next_addr); a following instruction at 0x204 -> no mispredict.
REQ-027 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken.
REQ-028 JALR with rs1=0x301, i_imm=0, C_EXT=1 -> target 0x300, exception 0. With C_EXT=0 and rs1=0x302 -> exception 1. funct3=010 -> exception 1, taken 0.
REQ-029 Mispredict count with MPCNT_W=2: force 5 mispredicts -> count reads 1,2,3,3,3.
REQ-030 JAL accepted, then rst_n low for 1 cycle, then an instruction at any address -> mispredict=0, count=0, output_valid=0 in the reset-following cycle.

Source files
------------

// File: rtl/exec_branch_unit_if.sv
// Decode-to-branch-unit bundle: instruction fields and operands in one direction,
// resolved branch results and the mispredict tracker outputs in the other.
interface exec_branch_unit_if #(
    parameter int XLEN    = 32,
    parameter int ALEN    = 32,
    parameter int MPCNT_W = 16
);
    logic [ALEN-1:0]    decode_instruction_addr;
    logic [ALEN-1:0]    decode_instruction_next_addr;
    logic [4:0]         opcode;
    logic [2:0]         funct3;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [20:1]        j_imm;
    logic [12:1]        b_imm;
    logic [11:0]        i_imm;
    logic               input_valid_unless_mispredict;
    logic               input_valid;
    logic               input_is_branch;

    logic               exec_branch_output_valid;
    logic               exec_branch_exception;
    logic               exec_branch_taken;
    logic [XLEN-1:0]    exec_branch_result;
    logic [ALEN-1:0]    exec_branch_target;
    logic               exec_mispredict_detected;
    logic [MPCNT_W-1:0] exec_mispredict_count;

    modport master (
        output decode_instruction_addr, decode_instruction_next_addr, opcode, funct3,
               rs1_data, rs2_data, j_imm, b_imm, i_imm,
               input_valid_unless_mispredict, input_valid, input_is_branch,
        input  exec_branch_output_valid, exec_branch_exception, exec_branch_taken,
               exec_branch_result, exec_branch_target,
               exec_mispredict_detected, exec_mispredict_count
    );

    modport slave (
        input  decode_instruction_addr, decode_instruction_next_addr, opcode, funct3,
               rs1_data, rs2_data, j_imm, b_imm, i_imm,
               input_valid_unless_mispredict, input_valid, input_is_branch,
        output exec_branch_output_valid, exec_branch_exception, exec_branch_taken,
               exec_branch_result, exec_branch_target,
               exec_mispredict_detected, exec_mispredict_count
    );
endinterface

// File: rtl/exec_branch_unit.sv
// Branch/jump resolution with registered results, plus a tracker that checks the
// next valid instruction address against the last resolved next PC.
module exec_branch_unit #(
    parameter int XLEN    = 32,
    parameter int ALEN    = 32,
    parameter int C_EXT   = 1,
    parameter int MPCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exec_branch_unit_if.slave    bus
);
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic       ALIGN4    = (C_EXT == 0);

    typedef enum logic {IDLE, EXPECT} state_t;

    logic [ALEN-1:0]    j_off;
    logic [ALEN-1:0]    b_off;
    logic [ALEN-1:0]    i_off;
    logic [ALEN-1:0]    jalr_sum;
    logic [ALEN-1:0]    target_calc;
    logic [ALEN-1:0]    next_pc;
    logic [XLEN-1:0]    link_value;
    logic               taken;
    logic               illegal;
    logic               exception;
    logic               accept;
    logic               mispredict;

    state_t             state_reg;
    state_t             state_next;
    logic [ALEN-1:0]    expected_pc_reg;
    logic [ALEN-1:0]    expected_pc_next;

    logic               valid_reg;
    logic               taken_reg;
    logic               exception_reg;
    logic [ALEN-1:0]    target_reg;
    logic [XLEN-1:0]    result_reg;
    logic [MPCNT_W-1:0] mp_count_reg;

    assign accept   = bus.input_valid && bus.input_is_branch;
    assign j_off    = {{(ALEN-21){bus.j_imm[20]}}, bus.j_imm, 1'b0};
    assign b_off    = {{(ALEN-13){bus.b_imm[12]}}, bus.b_imm, 1'b0};
    assign i_off    = {{(ALEN-12){bus.i_imm[11]}}, bus.i_imm};
    assign jalr_sum = bus.rs1_data[ALEN-1:0] + i_off;

    always_comb begin
        taken       = 1'b0;
        illegal     = 1'b0;
        target_calc = bus.decode_instruction_next_addr;
        case (bus.opcode)
            OP_JAL: begin
                taken       = 1'b1;
                target_calc = bus.decode_instruction_addr + j_off;
            end
            OP_JALR: begin
                taken       = 1'b1;
                target_calc = jalr_sum & ~ALEN'(1);
            end
            OP_BRANCH: begin
                target_calc = bus.decode_instruction_addr + b_off;
                case (bus.funct3)
                    3'b000:  taken = (bus.rs1_data == bus.rs2_data);
                    3'b001:  taken = (bus.rs1_data != bus.rs2_data);
                    3'b100:  taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
                    3'b101:  taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
                    3'b110:  taken = (bus.rs1_data <  bus.rs2_data);
                    3'b111:  taken = (bus.rs1_data >= bus.rs2_data);
                    default: illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign next_pc   = taken ? target_calc : bus.decode_instruction_next_addr;
    assign exception = illegal || (taken && target_calc[0]) || (taken && ALIGN4 && target_calc[1]);

    // Link value is the next address, zero-extended or truncated to the register width.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_link
        if (gi < ALEN) begin : g_bit
            assign link_value[gi] = bus.decode_instruction_next_addr[gi];
        end else begin : g_zero
            assign link_value[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            taken_reg     <= 1'b0;
            exception_reg <= 1'b0;
        end else begin
            valid_reg <= accept;
            if (accept) begin
                taken_reg     <= taken;
                exception_reg <= exception;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            target_reg <= next_pc;
            result_reg <= link_value;
        end
    end

    // Tracker only moves on cycles that carry a real instruction slot; stalls hold it.
    always_comb begin
        state_next       = state_reg;
        expected_pc_next = expected_pc_reg;
        if (bus.input_valid_unless_mispredict) begin
            if (accept) begin
                state_next       = EXPECT;
                expected_pc_next = next_pc;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        expected_pc_reg <= expected_pc_next;
    end

    assign mispredict = bus.input_valid_unless_mispredict && (state_reg == EXPECT) &&
                        (expected_pc_reg != bus.decode_instruction_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mp_count_reg <= '0;
        end else if (mispredict && (mp_count_reg != {MPCNT_W{1'b1}})) begin
            mp_count_reg <= mp_count_reg + MPCNT_W'(1);
        end
    end

    assign bus.exec_branch_output_valid = valid_reg;
    assign bus.exec_branch_taken        = taken_reg;
    assign bus.exec_branch_exception    = exception_reg;
    assign bus.exec_branch_target       = target_reg;
    assign bus.exec_branch_result       = result_reg;
    assign bus.exec_mispredict_detected = mispredict;
    assign bus.exec_mispredict_count    = mp_count_reg;
endmodule
